// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               requesters. Each operation runs as accept (IDLE), one execute
//               cycle (EXEC), then a held response (RESP) to the granted
//               requester.
//               Optional grant counters: define ALU_SHARE_ARBITER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_rs_data,
    input  logic [2*WIDTH-1:0]   req_rt_data,
    input  logic [2*SHW-1:0]     req_shamt,
    input  logic [3:0]           req_funct,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_zero,
    output logic [WIDTH-1:0]     alu_rs_data,
    output logic [WIDTH-1:0]     alu_rt_data,
    output logic [SHW-1:0]       alu_shamt,
    output logic [1:0]           alu_funct,
    input  logic [WIDTH-1:0]     alu_rd_data,
    input  logic                 alu_zero
`ifdef ALU_SHARE_ARBITER_STATS_EN
    ,
    output logic [15:0]          grant_cnt0,
    output logic [15:0]          grant_cnt1
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_rr_ptr;
    logic             r_grant;
    logic [WIDTH-1:0] r_rs;
    logic [WIDTH-1:0] r_rt;
    logic [SHW-1:0]   r_shamt;
    logic [1:0]       r_funct;
    logic [WIDTH-1:0] r_rd;
    logic             r_zero;

    logic             w_winner;
    logic             w_accept;
    logic             w_rsp_hs;

    // Favoured requester wins when valid, otherwise the other one.
    // Reset gates acceptance so req_ready drops as soon as rst_n falls.
    assign w_winner = req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
    assign w_accept = rst_n && (r_state == c_IDLE) && (|req_valid);
    assign w_rsp_hs = (r_state == c_RESP) && rsp_ready[r_grant];

    // ALU is always fed from the latched operands so it is stable outside EXEC.
    assign alu_rs_data = r_rs;
    assign alu_rt_data = r_rt;
    assign alu_shamt   = r_shamt;
    assign alu_funct   = r_funct;
    assign rsp_data    = r_rd;
    assign rsp_zero    = r_zero;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = c_EXEC;
            c_EXEC:  w_state_nxt = c_RESP;
            c_RESP:  if (w_rsp_hs) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Handshake outputs: one-hot ready in IDLE, one-hot response valid in RESP.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (w_accept) begin
            req_ready[w_winner] = 1'b1;
        end
        if (r_state == c_RESP) begin
            rsp_valid[r_grant] = 1'b1;
        end
    end

    // Operand capture, result capture and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
            r_grant  <= 1'b0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_shamt  <= '0;
            r_funct  <= 2'b00;
            r_rd     <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_winner;
                r_rs    <= w_winner ? req_rs_data[2*WIDTH-1:WIDTH] : req_rs_data[WIDTH-1:0];
                r_rt    <= w_winner ? req_rt_data[2*WIDTH-1:WIDTH] : req_rt_data[WIDTH-1:0];
                r_shamt <= w_winner ? req_shamt[2*SHW-1:SHW]       : req_shamt[SHW-1:0];
                r_funct <= w_winner ? req_funct[3:2]               : req_funct[1:0];
            end
            if (r_state == c_EXEC) begin
                r_rd   <= alu_rd_data;
                r_zero <= alu_zero;
            end
            // Pointer moves only when the response is taken, not on accept.
            if (w_rsp_hs) begin
                r_rr_ptr <= ~r_grant;
            end
        end
    end

`ifdef ALU_SHARE_ARBITER_STATS_EN
    // Saturating per-requester accept counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= 16'h0000;
            grant_cnt1 <= 16'h0000;
        end else if (w_accept) begin
            if (!w_winner && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (w_winner && grant_cnt1 != 16'hFFFF)  grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (funct 0 add, 1 sub, 2 shift-left by shamt, 3 OR; result plus zero flag) between two requesters.
- Round-robin arbitration, valid/ready request handshake, operand capture, one execute cycle, then a held response per requester.
- Sits between two issue sources (e.g. main datapath and address/branch unit) and the single ALU instance.

Parameters:
- WIDTH, 32, data width of Rs/Rt/Rd.
- SHW, 5, shift-amount width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  bit i: requester i has an operation.
- req_ready  out  2  bit i: operation from requester i accepted this cycle.
- req_rs_data  in  2*WIDTH  [i*WIDTH +: WIDTH] = Rs of requester i.
- req_rt_data  in  2*WIDTH  Rt per requester, same packing.
- req_shamt  in  2*SHW  shift amount per requester.
- req_funct  in  4  [2i +: 2] = funct of requester i.
- rsp_valid  out  2  bit i: result for requester i held.
- rsp_ready  in  2  bit i: requester i takes its result.
- rsp_data  out  WIDTH  result, valid when any rsp_valid bit set.
- rsp_zero  out  1  zero flag of rsp_data.
- alu_rs_data  out  WIDTH  to ALU Rs.
- alu_rt_data  out  WIDTH  to ALU Rt.
- alu_shamt  out  SHW  to ALU shamt.
- alu_funct  out  2  to ALU funct.
- alu_rd_data  in  WIDTH  from ALU result.
- alu_zero  in  1  from ALU zero.

Behaviour:
- FSM states IDLE, EXEC, RESP. Reset: state IDLE, rr pointer = 0 (requester 0 favoured), grant reg 0, operand/result regs 0, req_ready 0, rsp_valid 0, rsp_data 0, rsp_zero 0, alu_* 0.
- IDLE: winner = favoured requester if its req_valid is high, else the other if valid. req_ready[winner] asserted combinationally only in IDLE, at most one bit. On the accepting edge: latch winner's Rs/Rt/shamt/funct, grant <= winner, -> EXEC. No valid: stay IDLE.
- EXEC: alu_* driven from latched operand regs (alu_* always driven from those regs, so they are stable outside EXEC). At end of EXEC cycle capture alu_rd_data/alu_zero into result regs, -> RESP. Exactly one cycle.
- RESP: rsp_valid[grant] = 1, other bit 0; rsp_data/rsp_zero from result regs, stable until handshake. On rsp_valid[grant] & rsp_ready[grant]: rr pointer <= ~grant, -> IDLE. rsp_ready of the non-granted requester ignored.
- Latency: accept at edge T -> rsp_valid high from T+2 cycle. Peak throughput one op per 3 cycles (rsp_ready tied high).
- No new request accepted outside IDLE; req_ready 0 in EXEC/RESP; requesters hold req_* stable until req_ready.
- Fairness: both valid continuously -> grants alternate 0,1,0,1. Single requester always valid -> served every op regardless of pointer.
- Pointer updates only on response handshake, not on accept.
- Arithmetic entirely in the ALU; arbiter does no width conversion. funct 2 uses shamt only; Rt still forwarded.
- Reset mid-operation (any state): all of the above reset values immediately; in-flight op dropped, no response issued.
- rsp_zero is the captured alu_zero, not recomputed.

Optional Feature:
- Macro ALU_SHARE_ARBITER_STATS_EN. Defined: extra outputs grant_cnt0, grant_cnt1 (16 bits each), increment on each accept for that requester, saturate at 16'hFFFF, reset to 0 by rst_n. Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then req_valid=01, Rs=5, Rt=3, funct=0, rsp_ready=1 -> req_ready=01 one cycle, rsp_valid=01 two cycles later, rsp_data=8, rsp_zero=0.
- Req1 only, Rs=7, Rt=7, funct=1 -> rsp_valid=10, rsp_data=0, rsp_zero=1; alu_funct=1 during EXEC.
- Both valid held 4 ops: req0 funct=2 Rs=1 shamt=4, req1 funct=3 Rs=F0 Rt=0F -> grant order 0,1,0,1; rsp_data 16 for req0, FF for req1.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready stays 00 despite req_valid=11; after rsp_ready, next grant to other requester.
- rst_n asserted low during EXEC -> req_ready, rsp_valid, alu_* all 0 immediately; after release, pending req0 accepted first, no stale response.
- With ALU_SHARE_ARBITER_STATS_EN: 3 req0 + 2 req1 ops -> grant_cnt0=3, grant_cnt1=2; rst_n clears both.
